puf_array_ctrl: RTL
===================

Name: puf_array_ctrl

Overview:
Parametrised successor to the fixed four-instance delay-PUF hookup. One controller sequences an external array of N_PUF delay-PUF cores that share one challenge. It repeats each evaluation N_EVAL times and majority-votes every channel. It reports a voted response word plus a per-channel stability flag through a start/busy/done handshake driven from the LA bus.

Parameters:
N_PUF, 4, number of PUF channels driven and sampled (1..32)
CHAL_W, 8, challenge width in bits
N_EVAL, 5, evaluations per challenge; must be odd and >=1, otherwise elaboration error
ARM_CYC, 2, cycles puf_reset is held before each race (>=1)
SETTLE_CYC, 16, cycles puf_run is held before sampling (>=1)

Ports:
clk  in  1  system clock (wb_clk_i at top level)
reset_n  in  1  asynchronous active-low reset
start  in  1  request evaluation; level-sampled, accepted only in IDLE
abort  in  1  synchronous abort, returns to IDLE without done
challenge  in  CHAL_W  challenge, latched when start is accepted
puf_reset  out  1  reset to all PUF cores
puf_run  out  1  race enable to all PUF cores
puf_challenge  out  CHAL_W  latched challenge to all cores
puf_result  in  N_PUF  per-core arbiter outputs
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse when a result is committed
response  out  N_PUF  majority-voted response
stable  out  N_PUF  1 = all N_EVAL samples agreed for that channel

Behaviour:
- Reset (async assert, sync deassert handled at top level): state=IDLE, busy=0, done=0, puf_reset=1, puf_run=0, puf_challenge=0, response=0, stable=0, all counters=0.
- FSM states: IDLE, ARM, RUN, SAMPLE, DONE.
- IDLE: puf_reset=1, puf_run=0. If start=1 at edge k: latch challenge into puf_challenge, clear eval_cnt and per-channel ones_cnt, go to ARM. busy=1 from cycle k+1.
- ARM: puf_reset=1, puf_run=0 for exactly ARM_CYC cycles, then go to RUN.
- RUN: puf_reset=0, puf_run=1 for exactly SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: one cycle; puf_reset=0, puf_run=1. For each channel, ones_cnt[i] += puf_result[i]. If eval_cnt==N_EVAL-1, go to DONE; else increment eval_cnt and go to ARM.
- Counter widths: $clog2(N_EVAL+1) for ones_cnt, $clog2(N_EVAL) (min 1) for eval_cnt. No wrap is possible.
- DONE: one cycle; puf_reset=1, puf_run=0, done=1, busy=1.
  - response[i] = (ones_cnt[i] > N_EVAL/2), registered and visible in the DONE cycle.
  - stable[i] = (ones_cnt[i]==0 || ones_cnt[i]==N_EVAL).
  - Next state is IDLE, with busy=0 from the following cycle.
- Timing: E = ARM_CYC + SETTLE_CYC + 1 cycles per evaluation. For start accepted at edge k, done is high in cycle k + 1 + N_EVAL*E. Defaults give E=19 and done at k+96.
- response/stable hold their last committed value until the next DONE. They are never partially updated.
- start asserted while busy is ignored; no queuing. start held high through DONE triggers a new run on the first IDLE cycle.
- abort=1 in any non-IDLE state → IDLE next cycle.
  - busy drops and no done pulse is produced.
  - response/stable are unchanged.
  - abort has priority over start and over state transitions.
- challenge changes while busy have no effect.
- reset_n assertion mid-operation forces the reset values immediately, including response=0.
- N_EVAL=1: response = single sample and stable = all ones.

Test Plan:
- Reset: reset_n=0 mid-RUN → busy=0, done=0, puf_reset=1, puf_run=0, response=0 asynchronously; hold 0 until first start.
- Nominal defaults: model cores return constant puf_result=4'b1010; start with challenge=8'h5A at edge k → puf_challenge=8'h5A, done pulse exactly at k+96, response=4'b1010, stable=4'b1111, busy low at k+97.
- Voting: model ch0 returns 1,1,0,1,0 (3/5), ch1 returns 0,0,1,0,0 → response[0]=1, stable[0]=0, response[1]=0, stable[1]=0.
- Ignored start / challenge change: pulse start and change challenge to 8'hFF during RUN → single done at k+96, puf_challenge stays 8'h5A throughout.
- Abort: abort=1 during the third SAMPLE → IDLE next cycle, no done pulse, response retains the prior value 4'b1010. A fresh start afterwards completes normally.
- Parameter sweep: N_PUF=8, N_EVAL=1, ARM_CYC=1, SETTLE_CYC=1 → E=3, done at k+4, response = sampled value, stable=8'hFF. Also confirm N_EVAL=4 fails elaboration.

Source files
------------

// File: rtl/puf_array_ctrl.sv
// puf_array_ctrl: sequences a shared-challenge array of delay-PUF cores.
// Each challenge is evaluated N_EVAL times. Every channel is majority-voted
// and flagged stable when all of its samples agreed.
module puf_array_ctrl #(
    parameter int N_PUF      = 4,
    parameter int CHAL_W     = 8,
    parameter int N_EVAL     = 5,
    parameter int ARM_CYC    = 2,
    parameter int SETTLE_CYC = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CHAL_W-1:0] challenge,
    output logic              puf_reset,
    output logic              puf_run,
    output logic [CHAL_W-1:0] puf_challenge,
    input  logic [N_PUF-1:0]  puf_result,
    output logic              busy,
    output logic              done,
    output logic [N_PUF-1:0]  response,
    output logic [N_PUF-1:0]  stable
);

    localparam int OW   = $clog2(N_EVAL + 1);
    localparam int EW   = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;
    localparam int PMAX = (ARM_CYC > SETTLE_CYC) ? ARM_CYC : SETTLE_CYC;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX + 1) : 1;

    localparam logic [PW-1:0] ARM_LAST = PW'(ARM_CYC - 1);
    localparam logic [PW-1:0] RUN_LAST = PW'(SETTLE_CYC - 1);
    localparam logic [EW-1:0] EVAL_LAST = EW'(N_EVAL - 1);
    localparam logic [OW-1:0] HALF      = OW'(N_EVAL / 2);
    localparam logic [OW-1:0] ALL_ONES  = OW'(N_EVAL);

    // An even vote count could tie, so reject it at elaboration.
    if ((N_EVAL < 1) || ((N_EVAL % 2) == 0)) begin : g_bad_eval
        $error("puf_array_ctrl: N_EVAL must be odd and >= 1");
    end
    if ((N_PUF < 1) || (N_PUF > 32)) begin : g_bad_npuf
        $error("puf_array_ctrl: N_PUF must be in 1..32");
    end
    if ((ARM_CYC < 1) || (SETTLE_CYC < 1)) begin : g_bad_cyc
        $error("puf_array_ctrl: ARM_CYC and SETTLE_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        SAMPLE,
        DONE
    } state_t;

    state_t                     state;
    logic [EW-1:0]              eval_cnt;
    logic [PW-1:0]              phase_cnt;
    logic [N_PUF-1:0][OW-1:0]   ones_cnt;
    logic [N_PUF-1:0][OW-1:0]   ones_next;
    logic [N_PUF-1:0]           vote_resp;
    logic [N_PUF-1:0]           vote_stable;

    // Tallies including the sample being taken now, so the final SAMPLE can commit directly.
    always_comb begin
        ones_next   = ones_cnt;
        vote_resp   = '0;
        vote_stable = '0;
        for (int i = 0; i < N_PUF; i++) begin
            ones_next[i]   = ones_cnt[i] + OW'(puf_result[i]);
            vote_resp[i]   = (ones_next[i] > HALF);
            vote_stable[i] = (ones_next[i] == '0) || (ones_next[i] == ALL_ONES);
        end
    end

    // Controller FSM with all core-facing and handshake outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            puf_reset     <= 1'b1;
            puf_run       <= 1'b0;
            puf_challenge <= '0;
            response      <= '0;
            stable        <= '0;
            eval_cnt      <= '0;
            phase_cnt     <= '0;
            ones_cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                puf_reset <= 1'b1;
                puf_run   <= 1'b0;
                phase_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state         <= ARM;
                            busy          <= 1'b1;
                            puf_challenge <= challenge;
                            eval_cnt      <= '0;
                            phase_cnt     <= '0;
                            ones_cnt      <= '0;
                        end
                    end
                    ARM: begin
                        if (phase_cnt == ARM_LAST) begin
                            state     <= RUN;
                            phase_cnt <= '0;
                            puf_reset <= 1'b0;
                            puf_run   <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (phase_cnt == RUN_LAST) begin
                            state     <= SAMPLE;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    SAMPLE: begin
                        ones_cnt  <= ones_next;
                        puf_reset <= 1'b1;
                        puf_run   <= 1'b0;
                        if (eval_cnt == EVAL_LAST) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            response <= vote_resp;
                            stable   <= vote_stable;
                        end else begin
                            state    <= ARM;
                            eval_cnt <= eval_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
